crc32_d8: RTL and testbench

- Byte-parallel CRC-32 generator using the IEEE 802.3 polynomial 0x04C11DB7, in non-reflected (MSB-first) form.
- Consumes one 8-bit word per enabled clock and holds the running remainder in a 32-bit register.
- Used by the Ethernet RMII transmitter to compute the FCS over frame bytes.
- The caller bit-reverses each byte on input, and inverts and bit-reverses the result when transmitting.

---
 rtl/crc32_d8.sv | 71 +++++++
 tb/tb_crc32_d8.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/crc32_d8.sv
// crc32_d8 -- byte-parallel CRC-32 (IEEE 802.3 polynomial 0x04C11DB7),
// non-reflected / MSB-first form. One byte per enabled clock, data_in[7]
// is folded in first. crc_out is the raw remainder register: no final XOR
// and no reflection. The Ethernet caller bit-reverses each byte on the way
// in and sends ~bitrev32(crc_out) as the FCS.
//
// Optional feature: define CRC_CHECK_EN to add the crc_ok output, which
// flags the 802.3 good-frame residue after frame bytes plus received FCS.
module crc32_d8 #(
  parameter logic [31:0] INIT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        crc_en,
  output logic [31:0] crc_out
`ifdef CRC_CHECK_EN
  ,
  output logic        crc_ok
`endif
);

  localparam logic [31:0] POLY = 32'h04C11DB7;

  // Eight serial LFSR steps, d[7] first. The loop unrolls into a flat XOR
  // network, so the whole byte is absorbed in a single cycle.
  // NOTE: blocking assignments here are intentional; each iteration must see
  // the value produced by the previous one, which is how the serial shifts
  // collapse into one combinational function.
  function automatic logic [31:0] crc_next(input logic [31:0] r,
                                           input logic [7:0]  d);
    logic [31:0] c;
    logic        fb;
    c = r;
    for (int i = 7; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  logic [31:0] remainder;
  logic [31:0] remainder_next;

  // Next remainder if the current byte is folded in.
  always_comb begin
    remainder_next = crc_next(remainder, data_in);
  end

  // Remainder register: reset beats enable; otherwise hold.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      remainder <= INIT;
    end else if (crc_en) begin
      remainder <= remainder_next;
    end
  end

  assign crc_out = remainder;

`ifdef CRC_CHECK_EN
  // Good-frame residue in the non-reflected convention
  // (bit-reversed form of the familiar 0xDEBB20E3).
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;

  assign crc_ok = (remainder == RESIDUE);
`endif

endmodule

// File: tb/tb_crc32_d8.sv
// tb_crc32_d8 -- scoreboard bench for crc32_d8. The stimulus process pushes
// an expected entry and raises a mark alongside the byte it applies; a
// separate monitor pops and compares on the falling edge after that byte
// was clocked. Expected values are hand-computed constants.
module tb_crc32_d8;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        crc_en;
  logic [31:0] crc_out;
`ifdef CRC_CHECK_EN
  logic        crc_ok;
`endif

  crc32_d8 dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .crc_en  (crc_en),
    .crc_out (crc_out)
`ifdef CRC_CHECK_EN
    ,
    .crc_ok  (crc_ok)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          ne;   // expect crc_out to differ from exp
    bit          xf;   // compare ~bitrev32(crc_out) instead of crc_out
    bit          ok;   // expected crc_ok
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  logic        mark;
  logic        mark_q;
  logic        upd_q;
  bit          watch_hold;
  logic [31:0] last_neg;

  logic [7:0] ascii [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                            8'h36, 8'h37, 8'h38, 8'h39};
  logic [7:0] eth   [9] = '{8'h8C, 8'h4C, 8'hCC, 8'h2C, 8'hAC,
                            8'h6C, 8'hEC, 8'h1C, 8'h9C};
  // Each FCS byte 0x26,0x39,0xF4,0xCB bit-reversed.
  logic [7:0] fcs   [4] = '{8'h64, 8'h9C, 8'h2F, 8'hD3};

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input bit ne);
    bit pass;
    total++;
    pass = ne ? (act !== exp) : (act === exp);
    if (!pass) begin
      bad++;
      $display("FAIL %s: got %h, required %s%h", name, act,
               ne ? "not " : "", exp);
    end
  endtask

  // Capture, at the active edge, whether this edge updates the register
  // and whether a result is due.
  always @(posedge clk) begin
    mark_q <= mark;
    upd_q  <= crc_en | rst;
  end

  // Monitor: hold checks on idle cycles, scoreboard checks on marked ones.
  always @(negedge clk) begin
    exp_t e;
    if (watch_hold && !upd_q) check("hold", crc_out, last_neg, 1'b0);
    if (mark_q) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got no entry, required one");
      end else begin
        e = sb.pop_front();
        if (e.xf) check(e.name, ~bitrev32(crc_out), e.exp, e.ne);
        else      check(e.name, crc_out, e.exp, e.ne);
`ifdef CRC_CHECK_EN
        check({e.name, "_ok"}, {31'd0, crc_ok}, {31'd0, e.ok}, 1'b0);
`endif
      end
    end
    last_neg = crc_out;
  end

  task automatic cyc(input logic r, input logic e, input logic [7:0] d,
                     input logic mk);
    rst     = r;
    crc_en  = e;
    data_in = d;
    mark    = mk;
    @(posedge clk);
    #1;
    mark    = 1'b0;
  endtask

  task automatic push(input string name, input logic [31:0] exp,
                      input bit ne, input bit xf, input bit ok);
    exp_t e;
    e.name = name; e.exp = exp; e.ne = ne; e.xf = xf; e.ok = ok;
    sb.push_back(e);
  endtask

  task automatic do_reset(input string name);
    push(name, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'($urandom), 1'b1);
  endtask

  initial begin
    rst = 1'b1; crc_en = 1'b0; data_in = 8'h00; mark = 1'b0;
    watch_hold = 1'b0;
    @(posedge clk);
    #1;

    // Reset with crc_en high and data present: rst wins.
    push("reset", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hA5, 1'b1);

    // MPEG-2 check value, back-to-back bytes.
    for (int i = 0; i < 9; i++) begin
      if (i == 8) push("mpeg2", 32'h0376E6E7, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, ascii[i], i == 8);
    end
    push("mpeg2_idle", 32'h0376E6E7, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h5A, 1'b1);

    // Ethernet check: bit-reversed bytes, then derived FCS.
    do_reset("eth_reset");
    for (int i = 0; i < 9; i++) begin
      if (i == 8) push("eth", 32'h9B63D02C, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, eth[i], i == 8);
    end
    push("eth_fcs", 32'hCBF43926, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'hFF, 1'b1);

    // Gaps of 3 idle clocks with random data between bytes.
    do_reset("gap_reset");
    watch_hold = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) push("gaps", 32'h0376E6E7, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, ascii[i], i == 8);
      if (i < 8) repeat (3) cyc(1'b0, 1'b0, 8'($urandom), 1'b0);
    end
    cyc(1'b0, 1'b0, 8'($urandom), 1'b0);
    watch_hold = 1'b0;

    // Mid-stream reset discards accumulated bytes.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, ascii[i], 1'b0);
    do_reset("mid_reset");
    for (int i = 0; i < 9; i++) begin
      if (i == 8) push("mid_mpeg2", 32'h0376E6E7, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, ascii[i], i == 8);
    end

    // Good-frame residue: frame bytes followed by received FCS.
    do_reset("res_reset");
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, eth[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push("residue", 32'hC704DD7B, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, fcs[i], i == 3);
    end

    // Corrupted frame: one data bit flipped, residue must not appear.
    do_reset("bad_reset");
    for (int i = 0; i < 9; i++)
      cyc(1'b0, 1'b1, (i == 3) ? (eth[i] ^ 8'h10) : eth[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push("residue_bad", 32'hC704DD7B, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, fcs[i], i == 3);
    end

    // Drain: every pushed expectation must have been consumed.
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
